dpc_cfg_ctrl: RTL

Frame-synchronous configuration sequencer for the dead-pixel-correction datapath.
- Host side: collects manual bad-point entries into a staging RAM and holds shadow values of enable, frame_width and frame_height.
- On commit, waits for the current frame to end, then bursts the entries into the DPC manual LUT write port and swaps in the new configuration atomically.
- Stalls the pixel input while a reload is in progress, so no frame ever sees a half-loaded table.

---
 rtl/dpc_pkg.sv | 17 +
 rtl/dpc_stage_ram.sv | 21 ++
 rtl/dpc_cfg_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dpc_pkg.sv
// Shared constants for the DPC configuration sequencer: FSM encoding,
// staging capacity and LUT entry width.
package dpc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_APPLY = 2'd3;

  localparam int ENT_W = 32;

  // The top LUT address is reserved, so usable depth is one short of 2^bits.
  function automatic int stage_cap(input int bpb);
    return (1 << bpb) - 1;
  endfunction

endpackage

// File: rtl/dpc_stage_ram.sv
// Staging RAM: one write port and one registered read port.
module dpc_stage_ram #(
  parameter int AW = 7,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dpc_cfg_ctrl.sv
// Frame-synchronous configuration sequencer: stages bad-point entries, waits
// for frame end on commit, bursts them into the DPC LUT and swaps config.
module dpc_cfg_ctrl
  import dpc_pkg::*;
#(
  parameter int CNT_WIDTH     = 10,
  parameter int BAD_POINT_BIT = 7,
  parameter int FRAME_WIDTH   = 640,
  parameter int FRAME_HEIGHT  = 512
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic [CNT_WIDTH-1:0]     cfg_frame_width,
  input  logic [CNT_WIDTH-1:0]     cfg_frame_height,
  input  logic                     cfg_commit,
  input  logic                     ent_clear,
  input  logic                     ent_tvalid,
  output logic                     ent_tready,
  input  logic [ENT_W-1:0]         ent_tdata,
  input  logic                     pix_tvalid,
  input  logic                     pix_tready,
  input  logic                     pix_tuser,
  input  logic                     pix_tlast,
  output logic                     in_stall,
  output logic                     dpc_enable,
  output logic [CNT_WIDTH-1:0]     dpc_frame_width,
  output logic [CNT_WIDTH-1:0]     dpc_frame_height,
  output logic [BAD_POINT_BIT-1:0] dpc_bad_point_num,
  output logic                     wen_lut,
  output logic [BAD_POINT_BIT-1:0] waddr_lut,
  output logic [ENT_W-1:0]         wdata_lut,
  output logic                     busy,
  output logic                     load_done,
  output logic                     ent_overflow
);

  localparam logic [BAD_POINT_BIT-1:0] CAP = BAD_POINT_BIT'(stage_cap(BAD_POINT_BIT));

  logic [1:0]               state;
  logic [BAD_POINT_BIT-1:0] cnt, rd_ptr, lat_n;
  logic                     lat_en;
  logic [CNT_WIDTH-1:0]     lat_w, lat_h;
  logic                     frame_active;
  logic [CNT_WIDTH-1:0]     line_cnt, line_cur;
  logic [ENT_W-1:0]         rd_data;
  logic                     idle, hs, sof_hs, ent_acc;

  assign idle       = (state == ST_IDLE);
  assign busy       = ~idle;
  assign in_stall   = (state == ST_LOAD) | (state == ST_APPLY);
  assign load_done  = (state == ST_APPLY);
  assign hs         = pix_tvalid & pix_tready & ~in_stall;
  assign sof_hs     = hs & pix_tuser;
  assign ent_tready = idle & (cnt != CAP);
  assign ent_acc    = ent_tvalid & ent_tready & ~ent_clear;

  // Read of address r-1 returns this cycle, so the write trails the pointer.
  assign wen_lut   = (state == ST_LOAD) & (rd_ptr != '0);
  assign waddr_lut = wen_lut ? rd_ptr - 1'b1 : '0;
  assign wdata_lut = wen_lut ? rd_data : '0;

  dpc_stage_ram #(.AW(BAD_POINT_BIT), .DW(ENT_W)) u_ram (
    .clk   (clk),
    .we    (ent_acc),
    .waddr (cnt),
    .wdata (ent_tdata),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // A same-beat SOF+EOL ends line 0 of the new frame.
  assign line_cur = pix_tuser ? '0 : line_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_active <= 1'b0;
      line_cnt     <= '0;
    end else if (hs) begin
      if (pix_tlast) begin
        if (line_cur == dpc_frame_height - 1'b1) begin
          frame_active <= 1'b0;
          line_cnt     <= '0;
        end else begin
          frame_active <= frame_active | pix_tuser;
          line_cnt     <= line_cur + 1'b1;
        end
      end else if (pix_tuser) begin
        frame_active <= 1'b1;
        line_cnt     <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      ent_overflow <= 1'b0;
    end else if (idle) begin
      if (ent_clear) begin
        cnt          <= '0;
        ent_overflow <= 1'b0;
      end else begin
        if (ent_acc) cnt <= cnt + 1'b1;
        if (ent_tvalid && cnt == CAP) ent_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      rd_ptr            <= '0;
      lat_n             <= '0;
      lat_en            <= 1'b0;
      lat_w             <= CNT_WIDTH'(FRAME_WIDTH);
      lat_h             <= CNT_WIDTH'(FRAME_HEIGHT);
      dpc_enable        <= 1'b0;
      dpc_frame_width   <= CNT_WIDTH'(FRAME_WIDTH);
      dpc_frame_height  <= CNT_WIDTH'(FRAME_HEIGHT);
      dpc_bad_point_num <= '0;
    end else begin
      case (state)
        ST_IDLE: if (cfg_commit) begin
          state  <= ST_ARMED;
          lat_en <= cfg_enable;
          lat_w  <= cfg_frame_width;
          lat_h  <= cfg_frame_height;
          lat_n  <= cnt;
        end
        ST_ARMED: begin
          rd_ptr <= '0;
          if (!frame_active && !sof_hs) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (rd_ptr == lat_n) begin
            state             <= ST_APPLY;
            dpc_enable        <= lat_en;
            dpc_frame_width   <= lat_w;
            dpc_frame_height  <= lat_h;
            dpc_bad_point_num <= lat_n;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
